gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//  Parametrised, registered binary/Gray up-down counter. Successor to the 4-bit
//  combinational binary-to-Gray converter: adds clocking, width, direction,
//  parallel load in either code, and a wrap indication.
//  Sits between control logic and any consumer that needs a Gray-coded value:
//  clock-domain-crossing pointers, position encoders, glitch-free state buses.
// PARAMETERS
//  WIDTH      4   counter width in bits; legal range 2..32
//  RESET_VAL  0   binary value of the count after reset; must be < 2**WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  en           in   1      count enable; one step per clk while high
//  up           in   1      direction: 1 = increment, 0 = decrement
//  load         in   1      synchronous parallel load; overrides en
//  load_is_gray in   1      1 = load_val is Gray-coded, 0 = load_val is binary
//  load_val     in   WIDTH  value to load
//  bin_q        out  WIDTH  current count, binary
//  gray_q       out  WIDTH  current count, Gray (bin_q ^ (bin_q >> 1))
//  wrap         out  1      one-cycle pulse when the count wraps
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//  - Reset (rst_n=0): bin_q=RESET_VAL, gray_q=RESET_VAL^(RESET_VAL>>1), wrap=0.
//    Applies immediately, independent of clk; it aborts any load or count in flight.
//  - Priority on each rising clk edge: load > en > hold.
//  - load=1: if load_is_gray=1, decode load_val to binary
//    (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]); otherwise use load_val directly.
//    bin_q takes the decoded value and gray_q takes its Gray encoding. wrap=0.
//  - en=1, load=0: bin_q <= bin_q+1 (up=1) or bin_q-1 (up=0), modulo 2**WIDTH.
//  - en=0, load=0: all state holds; wrap=0.
//  - Latency: inputs are sampled at edge N; bin_q, gray_q and wrap are valid
//    after edge N. Both outputs come straight from flops, with no combinational
//    output path. gray_q is its own register; it is not decoded from bin_q
//    after the flop.
//  - Consecutive counted values of gray_q differ in exactly one bit, including
//    across the wrap. Loads may change any number of bits.
//  - wrap: registered. It is 1 for exactly the cycle after an edge where the
//    count went max->0 (up) or 0->max (down). It is 0 after any load.
//  - A direction change takes effect on the next enabled edge and needs no
//    dead cycle.
//  - Arithmetic is unsigned, WIDTH bits; carry out of the MSB is discarded.
// CONFIGURATION
//  Macro GRAY_CNT_SAT_EN:
//  - Defined: the counter saturates. At max with up=1, or at 0 with up=0, en
//    has no effect and the count holds. wrap stays 0 permanently. Loads are
//    unaffected.
//  - Undefined (default): modulo wrap and wrap pulse as described above.
// TESTING (WIDTH=4, RESET_VAL=0 unless noted)
//  1. rst_n=0 mid-count, asynchronous to clk -> bin_q=0 and gray_q=0000
//     immediately; wrap=0.
//  2. en=1, up=1 for 16 edges from 0 -> gray_q sequence 0000,0001,0011,0010,
//     ...,1000,0000. Exactly one bit changes per step. wrap=1 only after the
//     1111->0000 edge.
//  3. load=1, load_is_gray=1, load_val=1101 -> bin_q=1001, gray_q=1101, wrap=0.
//     The same edge with en=1 still loads.
//  4. bin_q=0, en=1, up=0 -> bin_q=1111, gray_q=1000, wrap=1 for one cycle.
//     Next edge with up=1 -> bin_q=0000, wrap=1 again.
//  5. With GRAY_CNT_SAT_EN defined: load binary 1110, then en=1, up=1 for 3
//     edges -> bin_q=1111, holding at 1111; wrap never asserts.
//  6. RESET_VAL=5, WIDTH=8 build -> after reset bin_q=0x05, gray_q=0x07.
//     Random en/up/load for 1000 cycles: the scoreboard model matches every
//     cycle.

Source files
------------

// File: rtl/gray_counter.sv
// Registered binary/Gray up-down counter with parallel load and wrap pulse.
// Define GRAY_CNT_SAT_EN to make the count saturate instead of wrapping.
module gray_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] load_dec;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;
    logic             acc;

    assign at_max  = (bin_q == ALL_ONES);
    assign at_zero = (bin_q == '0);

    // Gray-to-binary decode of the load value: running XOR from the MSB down.
    always_comb begin
        load_dec = '0;
        acc      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ load_val[i];
            load_dec[i] = acc;
        end
        load_bin = load_is_gray ? load_dec : load_val;
    end

    // Next count: load beats enable, enable beats hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
`ifdef GRAY_CNT_SAT_EN
                if (!at_max) begin
                    bin_d = bin_q + ONE;
                end
`else
                bin_d  = bin_q + ONE;
                wrap_d = at_max;
`endif
            end else begin
`ifdef GRAY_CNT_SAT_EN
                if (!at_zero) begin
                    bin_d = bin_q - ONE;
                end
`else
                bin_d  = bin_q - ONE;
                wrap_d = at_zero;
`endif
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Both codes are held in their own flops so gray_q never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector and scoreboard bench for gray_counter.
// Covers a 4-bit default instance and an 8-bit RESET_VAL=5 instance.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, load, lig;
    logic [3:0] val;
    logic [3:0] bin, gray;
    logic       wr;

    logic       e8, u8, l8, g8;
    logic [7:0] v8;
    logic [7:0] bin8, gray8;
    logic       wr8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(lig), .load_val(val),
        .bin_q(bin), .gray_q(gray), .wrap(wr)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(e8), .up(u8), .load(l8),
        .load_is_gray(g8), .load_val(v8),
        .bin_q(bin8), .gray_q(gray8), .wrap(wr8)
    );

    typedef struct {
        logic       ld;
        logic       lg;
        logic       en;
        logic       up;
        logic [3:0] val;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic ld, lg, e, u, input logic [3:0] v,
                       input logic [3:0] b, g, input logic w);
        vec_t t;
        t.ld = ld; t.lg = lg; t.en = e; t.up = u; t.val = v;
        t.bin = b; t.gray = g; t.wr = w;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ld, lg, e, u, input logic [3:0] v);
        @(negedge clk);
        load = ld; lig = lg; en = e; up = u; val = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gdec8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [3:0] gseq [16];
    logic [7:0] m;
    logic [7:0] nb;
    logic       mw;

    initial begin
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        rst_n = 1'b0;
        en = 0; up = 0; load = 0; lig = 0; val = '0;
        e8 = 0; u8 = 0; l8 = 0; g8 = 0; v8 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_bin4", bin, 4'h0);
        check("rst_gray4", gray, 4'h0);
        check("rst_wrap4", wr, 1'b0);
        check("rst_bin8", bin8, 8'h05);
        check("rst_gray8", gray8, 8'h07);
        check("rst_wrap8", wr8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef GRAY_CNT_SAT_EN
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 1, 4'h0, 4'((i + 1) % 16), gseq[i], i == 15);
        add(1, 1, 1, 1, 4'b1101, 4'b1001, 4'b1101, 0);
        add(0, 0, 0, 1, 4'h0,    4'b1001, 4'b1101, 0);
        add(0, 0, 1, 0, 4'h0,    4'b1000, 4'b1100, 0);
        add(1, 0, 0, 0, 4'h0,    4'b0000, 4'b0000, 0);
        add(0, 0, 1, 0, 4'h0,    4'b1111, 4'b1000, 1);
        add(0, 0, 1, 1, 4'h0,    4'b0000, 4'b0000, 1);
        add(0, 0, 1, 1, 4'h0,    4'b0001, 4'b0001, 0);
        add(1, 0, 0, 0, 4'b1110, 4'b1110, 4'b1001, 0);
        add(0, 0, 1, 1, 4'h0,    4'b1111, 4'b1000, 0);
        add(0, 0, 1, 1, 4'h0,    4'b0000, 4'b0000, 1);
        add(0, 0, 0, 0, 4'h0,    4'b0000, 4'b0000, 0);
        add(1, 1, 0, 0, 4'b1000, 4'b1111, 4'b1000, 0);
        add(0, 0, 1, 1, 4'h0,    4'b0000, 4'b0000, 1);
        add(1, 0, 1, 0, 4'b0101, 4'b0101, 4'b0111, 0);
        add(0, 0, 1, 1, 4'h0,    4'b0110, 4'b0101, 0);
`else
        add(1, 0, 0, 0, 4'b1110, 4'b1110, 4'b1001, 0);
        add(0, 0, 1, 1, 4'h0,    4'b1111, 4'b1000, 0);
        add(0, 0, 1, 1, 4'h0,    4'b1111, 4'b1000, 0);
        add(0, 0, 1, 1, 4'h0,    4'b1111, 4'b1000, 0);
        add(0, 0, 1, 0, 4'h0,    4'b1110, 4'b1001, 0);
        add(1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 1, 0, 4'h0,    4'b0000, 4'b0000, 0);
        add(0, 0, 1, 1, 4'h0,    4'b0001, 4'b0001, 0);
        add(1, 1, 1, 0, 4'b1101, 4'b1001, 4'b1101, 0);
`endif

        foreach (tv[i]) begin
            apply(tv[i].ld, tv[i].lg, tv[i].en, tv[i].up, tv[i].val);
            check($sformatf("vec%0d_bin", i), bin, tv[i].bin);
            check($sformatf("vec%0d_gray", i), gray, tv[i].gray);
            check($sformatf("vec%0d_wrap", i), wr, tv[i].wr);
        end

        apply(0, 0, 1, 1, 4'h0);
        apply(0, 0, 1, 1, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bin4", bin, 4'h0);
        check("async_gray4", gray, 4'h0);
        check("async_wrap4", wr, 1'b0);
        check("async_bin8", bin8, 8'h05);
        check("async_gray8", gray8, 8'h07);
        @(negedge clk);
        check("async_hold4", bin, 4'h0);
        en = 0;
        rst_n = 1'b1;

        m = 8'h05;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            e8 = 1'($urandom_range(0, 3) != 0);
            u8 = 1'($urandom_range(0, 1));
            l8 = 1'($urandom_range(0, 15) == 0);
            g8 = 1'($urandom_range(0, 1));
            v8 = 8'($urandom_range(0, 255));
            mw = 1'b0;
            if (l8) begin
                nb = g8 ? gdec8(v8) : v8;
            end else if (e8) begin
`ifdef GRAY_CNT_SAT_EN
                if (u8) nb = (m == 8'hff) ? m : m + 8'd1;
                else    nb = (m == 8'h00) ? m : m - 8'd1;
`else
                nb = u8 ? m + 8'd1 : m - 8'd1;
                mw = u8 ? (m == 8'hff) : (m == 8'h00);
`endif
            end else begin
                nb = m;
            end
            m = nb;
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", c), {bin8, gray8, wr8},
                  {m, m ^ (m >> 1), mw});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
